// File: rtl/de2_sram_ctrl_pkg.sv
// Shared types and helpers for the DE2 asynchronous SRAM controller.
// Holds the sequencer states, phase encoding and the per-phase bus image.
package de2_sram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2
   } state_t;

   localparam logic PHASE_LO = 1'b0;
   localparam logic PHASE_HI = 1'b1;

   typedef struct packed {
      logic        ce_n;
      logic        oe_n;
      logic        we_n;
      logic        lb_n;
      logic        ub_n;
      logic        data_oe;
      logic [15:0] data_o;
   } bus_t;

   localparam bus_t BUS_IDLE = '{
      ce_n:    1'b1,
      oe_n:    1'b1,
      we_n:    1'b1,
      lb_n:    1'b1,
      ub_n:    1'b1,
      data_oe: 1'b0,
      data_o:  16'h0000
   };

   function automatic logic [1:0] halfword_en(input logic [3:0] byteen, input logic phase);
      return phase ? byteen[3:2] : byteen[1:0];
   endfunction

   // Bus image for one cycle of a phase; strobe selects the we_n-low part of a write.
   function automatic bus_t phase_bus(input logic        write,
                                      input logic        phase,
                                      input logic [3:0]  byteen,
                                      input logic [31:0] wdata,
                                      input logic        strobe);
      bus_t       b;
      logic [1:0] en;
      en = halfword_en(byteen, phase);
      if (write) begin
         b.ce_n    = 1'b0;
         b.oe_n    = 1'b1;
         b.we_n    = ~strobe;
         b.lb_n    = ~en[0];
         b.ub_n    = ~en[1];
         b.data_oe = 1'b1;
         b.data_o  = phase ? wdata[31:16] : wdata[15:0];
      end else begin
         b.ce_n    = 1'b0;
         b.oe_n    = 1'b0;
         b.we_n    = 1'b1;
         b.lb_n    = 1'b0;
         b.ub_n    = 1'b0;
         b.data_oe = 1'b0;
         b.data_o  = 16'h0000;
      end
      return b;
   endfunction

endpackage

// File: rtl/de2_sram_ctrl.sv
// Sequences 32-bit data-memory requests onto the DE2 16-bit asynchronous SRAM
// as one or two halfword phases; the pad tri-state itself lives in the top level.
module de2_sram_ctrl
   import de2_sram_pkg::*;
#(
   parameter int ADDR_W      = 19,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_byteen,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic [ADDR_W-2:0] sram_addr,
   output logic [15:0]       sram_data_o,
   input  logic [15:0]       sram_data_i,
   output logic              sram_data_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_lb_n,
   output logic              sram_ub_n
);

   localparam int               CNT_W    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                wr;
   logic [ADDR_W-3:0]   word;
   logic [31:0]         wdata;
   logic [3:0]          byteen;
   logic [15:0]         rd_lo;
   bus_t                bus;
   logic                addr_lsb_unused;

   assign addr_lsb_unused = ^req_addr[1:0];

   assign sram_ce_n    = bus.ce_n;
   assign sram_oe_n    = bus.oe_n;
   assign sram_we_n    = bus.we_n;
   assign sram_lb_n    = bus.lb_n;
   assign sram_ub_n    = bus.ub_n;
   assign sram_data_oe = bus.data_oe;
   assign sram_data_o  = bus.data_o;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         wr        <= 1'b0;
         word      <= '0;
         wdata     <= '0;
         byteen    <= '0;
         rd_lo     <= '0;
         bus       <= BUS_IDLE;
         sram_addr <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  wr     <= req_write;
                  word   <= req_addr[ADDR_W-1:2];
                  wdata  <= req_wdata;
                  byteen <= req_byteen;
                  cnt    <= '0;
                  // Writes with no enabled byte in a halfword skip that phase entirely.
                  if (!req_write || halfword_en(req_byteen, PHASE_LO) != 2'b00) begin
                     state     <= LO;
                     req_ready <= 1'b0;
                     sram_addr <= {req_addr[ADDR_W-1:2], PHASE_LO};
                     bus       <= phase_bus(req_write, PHASE_LO, req_byteen, req_wdata, 1'b0);
                  end else if (halfword_en(req_byteen, PHASE_HI) != 2'b00) begin
                     state     <= HI;
                     req_ready <= 1'b0;
                     sram_addr <= {req_addr[ADDR_W-1:2], PHASE_HI};
                     bus       <= phase_bus(req_write, PHASE_HI, req_byteen, req_wdata, 1'b0);
                  end else begin
                     rsp_valid <= 1'b1;
                  end
               end
            end

            LO: begin
               if (cnt != CNT_LAST) begin
                  cnt <= cnt + CNT_W'(1);
                  bus <= phase_bus(wr, PHASE_LO, byteen, wdata, 1'b1);
               end else begin
                  if (!wr) begin
                     rd_lo <= sram_data_i;
                  end
                  if (!wr || halfword_en(byteen, PHASE_HI) != 2'b00) begin
                     state     <= HI;
                     cnt       <= '0;
                     sram_addr <= {word, PHASE_HI};
                     bus       <= phase_bus(wr, PHASE_HI, byteen, wdata, 1'b0);
                  end else begin
                     state     <= IDLE;
                     cnt       <= '0;
                     sram_addr <= '0;
                     bus       <= BUS_IDLE;
                     req_ready <= 1'b1;
                     rsp_valid <= 1'b1;
                  end
               end
            end

            HI: begin
               if (cnt != CNT_LAST) begin
                  cnt <= cnt + CNT_W'(1);
                  bus <= phase_bus(wr, PHASE_HI, byteen, wdata, 1'b1);
               end else begin
                  if (!wr) begin
                     rsp_rdata <= {sram_data_i, rd_lo};
                  end
                  state     <= IDLE;
                  cnt       <= '0;
                  sram_addr <= '0;
                  bus       <= BUS_IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               cnt       <= '0;
               sram_addr <= '0;
               bus       <= BUS_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_de2_sram_ctrl.sv
// Directed bench for de2_sram_ctrl: one instance at WAIT_CYCLES=1 backed by a
// byte-lane SRAM model, one at WAIT_CYCLES=3 backed by an address-pattern source.
module tb_de2_sram_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_write;
   logic [18:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_byteen;

   logic        req_valid, req_ready, rsp_valid;
   logic [31:0] rsp_rdata;
   logic [17:0] sram_addr;
   logic [15:0] sram_data_o, sram_data_i;
   logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

   logic        req_valid_3, req_ready_3, rsp_valid_3;
   logic [31:0] rsp_rdata_3;
   logic [17:0] sram_addr_3;
   logic [15:0] sram_data_o_3, sram_data_i_3;
   logic        sram_data_oe_3, sram_ce_n_3, sram_oe_n_3, sram_we_n_3, sram_lb_n_3, sram_ub_n_3;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   de2_sram_ctrl #(.ADDR_W(19), .WAIT_CYCLES(1)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .sram_addr(sram_addr), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
      .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
   );

   de2_sram_ctrl #(.ADDR_W(19), .WAIT_CYCLES(3)) u_dut_3 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_3), .req_ready(req_ready_3), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen),
      .rsp_valid(rsp_valid_3), .rsp_rdata(rsp_rdata_3),
      .sram_addr(sram_addr_3), .sram_data_o(sram_data_o_3), .sram_data_i(sram_data_i_3),
      .sram_data_oe(sram_data_oe_3), .sram_ce_n(sram_ce_n_3), .sram_oe_n(sram_oe_n_3),
      .sram_we_n(sram_we_n_3), .sram_lb_n(sram_lb_n_3), .sram_ub_n(sram_ub_n_3)
   );

   // Byte-lane SRAM model: a write lands when ce_n and we_n are low at a clock edge.
   logic [7:0] mem_lo [0:1023];
   logic [7:0] mem_hi [0:1023];

   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n && sram_data_oe) begin
         if (!sram_lb_n) mem_lo[sram_addr[9:0]] <= sram_data_o[7:0];
         if (!sram_ub_n) mem_hi[sram_addr[9:0]] <= sram_data_o[15:8];
      end
   end

   assign sram_data_i   = (!sram_ce_n && !sram_oe_n) ?
                          {mem_hi[sram_addr[9:0]], mem_lo[sram_addr[9:0]]} : 16'h0000;
   assign sram_data_i_3 = (!sram_ce_n_3 && !sram_oe_n_3) ?
                          (16'h1000 + 16'(sram_addr_3)) : 16'h0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [18:0] a, input logic [31:0] d, input logic [3:0] be);
      req_write  = w;
      req_addr   = a;
      req_wdata  = d;
      req_byteen = be;
   endtask

   initial begin
      int bad;
      int seen;
      reset       = 1'b0;
      req_valid   = 1'b0;
      req_valid_3 = 1'b0;
      drive(1'b0, 19'h0, 32'h0, 4'h0);
      repeat (3) tick();

      chk("rst req_ready", 32'(req_ready), 32'h1);
      chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1F);
      chk("rst data_oe", 32'(sram_data_oe), 32'h0);
      chk("rst addr", 32'(sram_addr), 32'h0);
      chk("rst data_o", 32'(sram_data_o), 32'h0);
      chk("rst rdata", rsp_rdata, 32'h0);
      reset = 1'b1;
      tick();

      // Full write 0xDEADBEEF @ 0x10
      drive(1'b1, 19'h00010, 32'hDEADBEEF, 4'hF);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("wr c1 addr", 32'(sram_addr), 32'h8);
      chk("wr c1 data", 32'(sram_data_o), 32'hBEEF);
      chk("wr c1 ce/we/oe", 32'({sram_ce_n, sram_we_n, sram_data_oe}), 32'b011);
      chk("wr c1 ready", 32'(req_ready), 32'h0);
      tick();
      chk("wr c2 addr", 32'(sram_addr), 32'h8);
      chk("wr c2 we_n", 32'(sram_we_n), 32'h0);
      tick();
      chk("wr c3 addr", 32'(sram_addr), 32'h9);
      chk("wr c3 data", 32'(sram_data_o), 32'hDEAD);
      chk("wr c3 we_n", 32'(sram_we_n), 32'h1);
      tick();
      chk("wr c4 we_n", 32'(sram_we_n), 32'h0);
      chk("wr c4 rsp", 32'(rsp_valid), 32'h0);
      tick();
      chk("wr c5 rsp", 32'(rsp_valid), 32'h1);
      chk("wr c5 idle", 32'({req_ready, sram_ce_n, sram_we_n, sram_data_oe}), 32'b1110);
      tick();
      chk("mem lo[8]", 32'(mem_lo[8]), 32'hEF);
      chk("mem hi[8]", 32'(mem_hi[8]), 32'hBE);
      chk("mem lo[9]", 32'(mem_lo[9]), 32'hAD);
      chk("mem hi[9]", 32'(mem_hi[9]), 32'hDE);

      // Full read @ 0x10
      drive(1'b0, 19'h00010, 32'h0, 4'h0);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      bad = 0;
      for (int c = 1; c <= 4; c++) begin
         if (sram_oe_n !== 1'b0 || sram_data_oe !== 1'b0 || rsp_valid !== 1'b0) bad++;
         tick();
      end
      chk("rd c1-4 oe_n/data_oe", 32'(bad), 32'h0);
      chk("rd c5 rsp", 32'(rsp_valid), 32'h1);
      chk("rd c5 rdata", rsp_rdata, 32'hDEADBEEF);
      tick();
      chk("rd c6 rsp", 32'(rsp_valid), 32'h0);
      chk("rd c6 rdata hold", rsp_rdata, 32'hDEADBEEF);

      // Single-phase byte write to byte 2
      drive(1'b1, 19'h00010, 32'h00AA0000, 4'h4);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("bw c1 addr", 32'(sram_addr), 32'h9);
      chk("bw c1 lb/ub", 32'({sram_lb_n, sram_ub_n}), 32'b01);
      chk("bw c1 data", 32'(sram_data_o), 32'h00AA);
      chk("bw c1 we_n", 32'(sram_we_n), 32'h1);
      tick();
      chk("bw c2 we_n", 32'(sram_we_n), 32'h0);
      chk("bw c2 rsp", 32'(rsp_valid), 32'h0);
      tick();
      chk("bw c3 rsp", 32'(rsp_valid), 32'h1);
      tick();

      // Empty write, with a read held behind it
      drive(1'b1, 19'h00010, 32'h12345678, 4'h0);
      req_valid = 1'b1;
      tick();
      drive(1'b0, 19'h00010, 32'h0, 4'h0);
      chk("ew c1 rsp", 32'(rsp_valid), 32'h1);
      chk("ew c1 ce_n", 32'(sram_ce_n), 32'h1);
      chk("ew c1 ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 1'b0;
      chk("ew c2 accepted", 32'({req_ready, sram_ce_n, sram_oe_n}), 32'b000);
      tick();
      tick();
      tick();
      tick();
      chk("ew readback rsp", 32'(rsp_valid), 32'h1);
      chk("ew readback rdata", rsp_rdata, 32'hDEAABEEF);
      tick();

      // Reset during HI phase of a read
      drive(1'b0, 19'h00010, 32'h0, 4'h0);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      chk("mr c3 addr", 32'(sram_addr), 32'h9);
      reset = 1'b0;
      tick();
      chk("mr strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1F);
      chk("mr data_oe/ready/rsp", 32'({sram_data_oe, req_ready, rsp_valid}), 32'b010);
      chk("mr rdata", rsp_rdata, 32'h0);
      reset = 1'b1;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid === 1'b1) seen++;
         tick();
      end
      chk("mr no rsp", 32'(seen), 32'h0);

      // Long strobe on the WAIT_CYCLES=3 instance
      drive(1'b0, 19'h00010, 32'h0, 4'h0);
      req_valid_3 = 1'b1;
      tick();
      bad = 0;
      for (int c = 1; c <= 8; c++) begin
         if (req_ready_3 !== 1'b0 || rsp_valid_3 !== 1'b0) bad++;
         if (sram_addr_3 !== ((c <= 4) ? 18'h8 : 18'h9)) bad++;
         tick();
      end
      chk("ls c1-8 busy/addr", 32'(bad), 32'h0);
      chk("ls c9 rsp", 32'(rsp_valid_3), 32'h1);
      chk("ls c9 rdata", rsp_rdata_3, 32'h10091008);
      chk("ls c9 ready", 32'(req_ready_3), 32'h1);
      tick();
      req_valid_3 = 1'b0;
      chk("ls c10 accepted", 32'(req_ready_3), 32'h0);
      seen = 0;
      for (int c = 0; c < 20 && seen == 0; c++) begin
         if (rsp_valid_3 === 1'b1) seen = 1;
         else tick();
      end
      chk("ls second rsp", 32'(seen), 32'h1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/de2_sram_ctrl.md
Name: de2_sram_ctrl

Overview:
Sequences the DE2 board's 16-bit asynchronous SRAM (IS61LV25616, 256K x 16) on behalf of the SoC's 32-bit data-memory bus. Each 32-bit request becomes one or two halfword SRAM phases, with programmable strobe width. The block drives address, strobes and the tri-state enable. The pad-level inout on sram_data stays in the top level (AppleSoC_de2).

Parameters:
ADDR_W, 19, byte-address width of the request port; SRAM address width is ADDR_W-1.
WAIT_CYCLES, 1, strobe cycles per halfword phase, minimum 1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address; bits [1:0] are ignored
req_wdata  in  32  write data, little-endian
req_byteen  in  4  write byte enables; ignored for reads
rsp_valid  out  1  one-cycle completion pulse, for both reads and writes
rsp_rdata  out  32  read data; valid with rsp_valid, holds until the next read completes
sram_addr  out  ADDR_W-1  halfword address
sram_data_o  out  16  write data to pad
sram_data_i  in  16  read data from pad
sram_data_oe  out  1  pad output enable
sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM controls

Behaviour:
- Reset, and IDLE bus state:
  - ce_n, oe_n, we_n, lb_n and ub_n are all 1.
  - data_oe = 0, sram_addr = 0, sram_data_o = 0.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0.
- All outputs come directly from flops.
- Accept: the handshake completes when req_valid && req_ready at a rising edge.
  - write, addr[ADDR_W-1:2], wdata and byteen are latched on that edge.
  - The requester holds the request stable until it is accepted; requests are never accepted while busy.
- States: IDLE -> LO -> HI -> IDLE.
  - LO phase: sram_addr = {word,0}, carries bytes 1:0.
  - HI phase: sram_addr = {word,1}, carries bytes 3:2.
  - A counter runs 0..WAIT_CYCLES within each phase, so every phase lasts WAIT_CYCLES+1 cycles.
- Read phase:
  - ce_n = 0, oe_n = 0, lb_n = ub_n = 0, data_oe = 0 for the whole phase.
  - sram_data_i is captured on the last cycle of the phase into the matching half of the read register.
- Write phase:
  - ce_n = 0, oe_n = 1, data_oe = 1, data_o = the selected halfword for the whole phase.
  - lb_n = ~byteen[2h], ub_n = ~byteen[2h+1], where h is the phase (0 = LO, 1 = HI).
  - Cycle 0 of the phase is address setup with we_n = 1.
  - Cycles 1..WAIT_CYCLES have we_n = 0.
  - we_n and data_oe deassert on the same edge at phase end.
- Phase skipping (writes only):
  - A phase whose two byte enables are both 0 is skipped: IDLE -> HI directly, or LO -> IDLE.
  - byteen = 0 does no SRAM access; rsp_valid pulses in the cycle after accept.
  - Reads always run both phases.
- Completion: rsp_valid pulses in the first IDLE cycle after the last phase. req_ready is also 1 in that cycle.
- Latency, with accept edge = cycle 0:
  - Full access: rsp_valid in cycle 2*(WAIT_CYCLES+1)+1.
  - Single-phase write: rsp_valid in cycle WAIT_CYCLES+2.
- Bus turnaround: the accept cycle is always IDLE on the bus, so at least one idle cycle separates back-to-back accesses. This prevents read/write contention.
- Reset mid-operation: the next edge forces the IDLE outputs. The in-flight request is dropped with no rsp_valid. An SRAM write may be partial.
- No backpressure on the response. The requester must accept rsp_valid unconditionally.

Decomposition:
- Package de2_sram_pkg holds:
  - state enum {IDLE, LO, HI};
  - PHASE_LO = 0 and PHASE_HI = 1;
  - helper function halfword_en(byteen, phase).
- No sub-module; the phase counter and FSM stay inline (about 150 lines).

Test Plan:
1. Full write (WAIT_CYCLES=1): write 0xDEADBEEF to 0x00010 with byteen 0xF.
   - LO phase, cycles 1-2: addr 0x00008, data 0xBEEF, we_n low in cycle 2 only.
   - HI phase, cycles 3-4: addr 0x00009, data 0xDEAD.
   - rsp_valid in cycle 5; SRAM model RAM_0[8]=0xEF, RAM_1[9]=0xDE.
2. Full read: read 0x00010.
   - oe_n low in cycles 1-4, data_oe = 0 throughout.
   - rsp_valid in cycle 5 with rsp_rdata = 0xDEADBEEF.
3. Single-phase byte write: write 0x00AA0000 to 0x00010 with byteen 0x4.
   - Only the HI phase runs: addr 0x00009, lb_n = 0, ub_n = 1; rsp_valid in cycle 3.
   - Readback returns 0xDEAABEEF.
4. Empty write: write with byteen 0x0.
   - ce_n never goes low; rsp_valid in cycle 1.
   - A second request held on req_valid is accepted in cycle 1.
5. Reset mid-operation: drive reset low during the HI phase of a read.
   - Next edge: all strobes 1, data_oe 0, req_ready 1, and no rsp_valid ever appears.
6. Long strobe (WAIT_CYCLES=3): read 0x00010.
   - Each phase lasts 4 cycles; rsp_valid in cycle 9.
   - req_valid asserted during cycles 1-8 is not accepted until cycle 9.
